// File: rtl/rv32i_regfile_alu_datapath_if.sv
// Controller-to-datapath bundle for the RV32I execute slice: register-file
// access, operand latches, ALU operands/flags and the captured ALU result.
interface rv32i_regfile_alu_datapath_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 4;

    logic            reg_write;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rfile_wr_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] reg_data1;
    logic [XLEN-1:0] reg_data2;
    logic [XLEN-1:0] reg_A;
    logic [XLEN-1:0] reg_B;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [OPW-1:0]  alu_control;
    logic [XLEN-1:0] alu_result;
    logic            overflow;
    logic            zero;
    logic            equal;
    logic            ALU_ena;
    logic [XLEN-1:0] alu_last;

    modport master (
        output reg_write, rd, rfile_wr_data, rs1, rs2,
               src_a, src_b, alu_control, ALU_ena,
        input  reg_data1, reg_data2, reg_A, reg_B,
               alu_result, overflow, zero, equal, alu_last
    );

    modport slave (
        input  reg_write, rd, rfile_wr_data, rs1, rs2,
               src_a, src_b, alu_control, ALU_ena,
        output reg_data1, reg_data2, reg_A, reg_B,
               alu_result, overflow, zero, equal, alu_last
    );
endinterface

// File: rtl/rv32i_regfile_alu_datapath.sv
// Execute-side datapath of the multicycle RV32I core: 32x32 register file,
// A/B operand latches, combinational ALU and the enabled ALU-result register.
module rv32i_regfile_alu_datapath #(
    parameter int unsigned N        = 32,
    parameter int unsigned RF_DEPTH = 32
) (
    input logic                          clk,
    input logic                          rst,
    rv32i_regfile_alu_datapath_if.slave  dp
);
    localparam int unsigned AW = $clog2(RF_DEPTH);
    localparam int unsigned SW = $clog2(N);

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    logic [N-1:0]  rf [RF_DEPTH];
    logic [N-1:0]  rd_data1;
    logic [N-1:0]  rd_data2;
    logic [N-1:0]  reg_a_q;
    logic [N-1:0]  reg_b_q;
    logic [N-1:0]  alu_last_q;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [SW-1:0] shamt;
    logic [N-1:0]  alu_res_c;
    logic          ovf_c;

    assign op_a  = dp.src_a;
    assign op_b  = dp.src_b;
    assign shamt = op_b[SW-1:0];

    // Asynchronous reads; x0 is forced to zero regardless of storage.
    always_comb begin
        rd_data1 = (dp.rs1 == '0) ? '0 : rf[dp.rs1];
        rd_data2 = (dp.rs2 == '0) ? '0 : rf[dp.rs2];
    end

    // Write port; reads in the same cycle still see the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                rf[AW'(i)] <= '0;
            end
        end else if (dp.reg_write && (dp.rd != '0)) begin
            rf[dp.rd] <= dp.rfile_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            alu_last_q <= '0;
        end else begin
            reg_a_q <= rd_data1;
            reg_b_q <= rd_data2;
            if (dp.ALU_ena) begin
                alu_last_q <= alu_res_c;
            end
        end
    end

    // ALU; unlisted opcodes yield zero with no overflow.
    always_comb begin
        alu_res_c = '0;
        ovf_c     = 1'b0;
        case (dp.alu_control)
            OP_AND:  alu_res_c = op_a & op_b;
            OP_OR:   alu_res_c = op_a | op_b;
            OP_XOR:  alu_res_c = op_a ^ op_b;
            OP_SLL:  alu_res_c = op_a << shamt;
            OP_SRL:  alu_res_c = op_a >> shamt;
            OP_SRA:  alu_res_c = N'($signed(op_a) >>> shamt);
            OP_ADD: begin
                alu_res_c = op_a + op_b;
                ovf_c     = (op_a[N-1] == op_b[N-1]) && (alu_res_c[N-1] != op_a[N-1]);
            end
            OP_SUB: begin
                alu_res_c = op_a - op_b;
                ovf_c     = (op_a[N-1] != op_b[N-1]) && (alu_res_c[N-1] != op_a[N-1]);
            end
            OP_SLT:  alu_res_c = N'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res_c = N'(op_a < op_b);
            default: alu_res_c = '0;
        endcase
    end

    assign dp.reg_data1  = rd_data1;
    assign dp.reg_data2  = rd_data2;
    assign dp.reg_A      = reg_a_q;
    assign dp.reg_B      = reg_b_q;
    assign dp.alu_result = alu_res_c;
    assign dp.overflow   = ovf_c;
    assign dp.zero       = (alu_res_c == '0);
    assign dp.equal      = (op_a == op_b);
    assign dp.alu_last   = alu_last_q;
endmodule

// File: tb/tb_rv32i_regfile_alu_datapath.sv
// Scoreboard bench for rv32i_regfile_alu_datapath: expectations are queued as
// stimulus is applied and compared against DUT outputs once they are due.
module tb_rv32i_regfile_alu_datapath;
    localparam int S_RD1 = 0, S_RD2 = 1, S_RA = 2, S_RB = 3, S_RES = 4,
                   S_OVF = 5, S_ZERO = 6, S_EQ = 7, S_LAST = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic [31:0] rf_m [32];
    logic [31:0] last_m;

    rv32i_regfile_alu_datapath_if dp_if ();

    rv32i_regfile_alu_datapath dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_obs(input int sel);
        case (sel)
            S_RD1:   return dp_if.reg_data1;
            S_RD2:   return dp_if.reg_data2;
            S_RA:    return dp_if.reg_A;
            S_RB:    return dp_if.reg_B;
            S_RES:   return dp_if.alu_result;
            S_OVF:   return 32'(dp_if.overflow);
            S_ZERO:  return 32'(dp_if.zero);
            S_EQ:    return 32'(dp_if.equal);
            default: return dp_if.alu_last;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, get_obs(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU using 64-bit signed arithmetic for the overflow decision.
    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ov);
        longint sa = longint'($signed(a));
        longint sb_v = longint'($signed(b));
        longint s;
        logic [4:0] sh = b[4:0];
        res = 32'd0;
        ov  = 1'b0;
        case (op)
            4'b0001: res = a & b;
            4'b0010: res = a | b;
            4'b0011: res = a ^ b;
            4'b0101: res = a << sh;
            4'b0110: res = a >> sh;
            4'b0111: res = 32'($signed(a) >>> sh);
            4'b1000: begin
                res = a + b;
                s = sa + sb_v;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1100: begin
                res = a - b;
                s = sa - sb_v;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1101: res = (sa < sb_v) ? 32'd1 : 32'd0;
            4'b1111: res = (a < b) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
    endfunction

    task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic ov);
        dp_if.alu_control = op;
        dp_if.src_a = a;
        dp_if.src_b = b;
        #1;
        push({tag, ".res"}, S_RES, res);
        push({tag, ".ovf"}, S_OVF, 32'(ov));
        push({tag, ".zero"}, S_ZERO, 32'(res == 32'd0));
        push({tag, ".eq"}, S_EQ, 32'(a == b));
        drain();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        dp_if.reg_write = 1'b1;
        dp_if.rd = addr;
        dp_if.rfile_wr_data = data;
        step();
        dp_if.reg_write = 1'b0;
        if (addr != 5'd0) rf_m[addr] = data;
    endtask

    initial begin
        logic [3:0]  codes [12] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hD, 4'hF, 4'h0, 4'h9};
        logic [31:0] r_exp;
        logic        o_exp;
        logic [31:0] a_v, b_v;
        logic [3:0]  op_v;

        rst = 1'b1;
        dp_if.reg_write = 1'b0;
        dp_if.rd = '0;
        dp_if.rfile_wr_data = '0;
        dp_if.rs1 = 5'd3;
        dp_if.rs2 = 5'd31;
        dp_if.src_a = '0;
        dp_if.src_b = '0;
        dp_if.alu_control = '0;
        dp_if.ALU_ena = 1'b0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        last_m = 32'd0;
        step();
        step();
        rst = 1'b0;
        #1;
        push("rst.rd1", S_RD1, 32'd0);
        push("rst.rd2", S_RD2, 32'd0);
        push("rst.regA", S_RA, 32'd0);
        push("rst.regB", S_RB, 32'd0);
        push("rst.last", S_LAST, 32'd0);
        drain();

        // Write then read back through port 0 and the A latch.
        write_reg(5'd5, 32'hDEADBEEF);
        dp_if.rs1 = 5'd5;
        #1;
        push("x5.rd1", S_RD1, 32'hDEADBEEF);
        drain();
        step();
        push("x5.regA", S_RA, 32'hDEADBEEF);
        drain();

        write_reg(5'd0, 32'h00001234);
        dp_if.rs1 = 5'd0;
        #1;
        push("x0.rd1", S_RD1, 32'd0);
        drain();

        // Same-cycle read and write of x7 returns the old value.
        write_reg(5'd7, 32'h11111111);
        dp_if.reg_write = 1'b1;
        dp_if.rd = 5'd7;
        dp_if.rfile_wr_data = 32'h22222222;
        dp_if.rs2 = 5'd7;
        #1;
        push("rw7.old", S_RD2, 32'h11111111);
        drain();
        push("rw7.regB", S_RB, 32'h11111111);
        step();
        dp_if.reg_write = 1'b0;
        rf_m[7] = 32'h22222222;
        drain();
        #1;
        push("rw7.new", S_RD2, 32'h22222222);
        drain();

        // Random writes/reads checked against the register model.
        for (int k = 0; k < 24; k++) begin
            dp_if.reg_write = 1'($urandom_range(1));
            dp_if.rd = 5'($urandom_range(31));
            dp_if.rfile_wr_data = $urandom();
            dp_if.rs1 = 5'($urandom_range(31));
            dp_if.rs2 = (k % 4 == 0) ? dp_if.rd : 5'($urandom_range(31));
            #1;
            push($sformatf("rnd%0d.rd1", k), S_RD1, rf_m[dp_if.rs1]);
            push($sformatf("rnd%0d.rd2", k), S_RD2, rf_m[dp_if.rs2]);
            drain();
            push($sformatf("rnd%0d.regA", k), S_RA, rf_m[dp_if.rs1]);
            push($sformatf("rnd%0d.regB", k), S_RB, rf_m[dp_if.rs2]);
            step();
            if (dp_if.reg_write && dp_if.rd != 5'd0) rf_m[dp_if.rd] = dp_if.rfile_wr_data;
            drain();
        end
        dp_if.reg_write = 1'b0;

        // Directed ALU cases with hand-computed results.
        run_alu("add_ovf", 4'b1000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
        run_alu("sub_eq",  4'b1100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        run_alu("sub_ovf", 4'b1100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
        run_alu("add_neg", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_alu("slt",     4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        run_alu("sltu",    4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_alu("sra",     4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        run_alu("srl",     4'b0110, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        run_alu("sll_b5",  4'b0101, 32'h00000003, 32'h00000021, 32'h00000006, 1'b0);
        run_alu("and",     4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        run_alu("or",      4'b0010, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0);
        run_alu("xor",     4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0);
        run_alu("inv0",    4'b0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0);
        run_alu("inv9",    4'b1001, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0);

        for (int k = 0; k < 40; k++) begin
            op_v = codes[$urandom_range(11)];
            a_v = $urandom();
            b_v = ($urandom_range(3) == 0) ? a_v : $urandom();
            alu_ref(op_v, a_v, b_v, r_exp, o_exp);
            run_alu($sformatf("alu%0d", k), op_v, a_v, b_v, r_exp, o_exp);
        end

        // alu_last captures only when enabled.
        dp_if.alu_control = 4'b1000;
        dp_if.src_a = 32'd1;
        dp_if.src_b = 32'd2;
        dp_if.ALU_ena = 1'b1;
        step();
        push("last.cap", S_LAST, 32'd3);
        drain();
        dp_if.ALU_ena = 1'b0;
        dp_if.src_a = 32'd100;
        step();
        push("last.hold1", S_LAST, 32'd3);
        drain();
        dp_if.alu_control = 4'b0011;
        step();
        push("last.hold2", S_LAST, 32'd3);
        drain();
        dp_if.alu_control = 4'b1000;
        dp_if.ALU_ena = 1'b1;
        step();
        push("last.cap2", S_LAST, 32'd102);
        drain();

        // Reset wins over a same-cycle write and ALU capture.
        dp_if.reg_write = 1'b1;
        dp_if.rd = 5'd9;
        dp_if.rfile_wr_data = 32'h0000AAAA;
        dp_if.rs1 = 5'd5;
        dp_if.rs2 = 5'd7;
        dp_if.src_a = 32'd7;
        rst = 1'b1;
        step();
        rst = 1'b0;
        dp_if.reg_write = 1'b0;
        dp_if.ALU_ena = 1'b0;
        push("rst2.regA", S_RA, 32'd0);
        push("rst2.regB", S_RB, 32'd0);
        push("rst2.last", S_LAST, 32'd0);
        drain();
        for (int i = 0; i < 32; i++) begin
            dp_if.rs1 = 5'(i);
            dp_if.rs2 = 5'(31 - i);
            #1;
            push($sformatf("rst2.x%0d", i), S_RD1, 32'd0);
            push($sformatf("rst2.y%0d", 31 - i), S_RD2, 32'd0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
